// File: rtl/serial_adder_sequencer.sv
// serial_adder_sequencer
//   Adds two WIDTH-bit operands by stepping an external combinational
//   two-bit full adder one 2-bit slice per clock, least significant slice
//   first. Each slice's carry-out is registered and returned as the next
//   slice's carry-in. The finished sum is assembled in a result register.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           request, sampled only while idle
//   op_a, op_b, cin operands, captured on the accepting edge
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse, result/cout valid
//   result, cout    (op_a + op_b + cin) split into sum and carry, held until next accept
//   add_a, add_b    current 2-bit operand slices to the external adder
//   add_cin         running carry to the external adder
//   add_sum         sum returned by the external adder
//   add_cout        carry returned by the external adder
module serial_adder_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [1:0]       add_a,
  output logic [1:0]       add_b,
  output logic             add_cin,
  input  logic [1:0]       add_sum,
  input  logic             add_cout
);

  localparam int unsigned N     = WIDTH / 2;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Reject odd or too-small widths at elaboration.
  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_adder_sequencer: WIDTH must be even and >= 2");
  end

  logic [1:0]       state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [1:0]       add_a_q,  add_a_d;
  logic [1:0]       add_b_q,  add_b_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      add_a_q  <= 2'b00;
      add_b_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
    end
  end

  // Next-state and next-output logic. Adder-facing slices are produced one
  // cycle ahead so that add_a/add_b/add_cin come straight from flops.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = op_a;
          b_d      = op_b;
          carry_d  = cin;
          idx_d    = '0;
          result_d = '0;
          add_a_d  = op_a[1:0];
          add_b_d  = op_b[1:0];
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[{idx_q, 1'b0} +: 2] = add_sum;
        if (idx_q == LAST_IDX) begin
          // Final slice: publish carry, park the adder inputs at zero.
          cout_d  = add_cout;
          done_d  = 1'b1;
          carry_d = 1'b0;
          idx_d   = '0;
          add_a_d = 2'b00;
          add_b_d = 2'b00;
          state_d = DONE;
        end else begin
          carry_d = add_cout;
          idx_d   = idx_q + IDX_W'(1);
          add_a_d = a_q[{idx_d, 1'b0} +: 2];
          add_b_d = b_q[{idx_d, 1'b0} +: 2];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_cin = carry_q;

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Self-checking bench for serial_adder_sequencer (WIDTH = 8). Models the
// external adder combinationally and checks every cycle against a
// timeline model built from whole-word arithmetic.
module tb_serial_adder_sequencer;

  localparam int unsigned W = 8;
  localparam int unsigned N = W / 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a  = '0;
  logic [W-1:0] op_b  = '0;
  logic         cin   = 1'b0;
  logic         busy, done, cout, add_cin, add_cout;
  logic [W-1:0] result;
  logic [1:0]   add_a, add_b, add_sum;
  logic [2:0]   adder_tot;

  serial_adder_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // External two-bit full adder.
  assign adder_tot = 3'(add_a) + 3'(add_b) + 3'(add_cin);
  assign add_sum   = adder_tot[1:0];
  assign add_cout  = adder_tot[2];

  always #5 clk = ~clk;

  int tests      = 0;
  int errors     = 0;
  int done_seen  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1..N working on slice phase-1, N+1 done.
  int           p      = 0;
  logic [W-1:0] ea     = '0;
  logic [W-1:0] eb     = '0;
  logic         ec     = 1'b0;
  logic [W:0]   esum   = '0;
  logic [W-1:0] eres   = '0;
  logic         ecout  = 1'b0;
  logic [1:0]   exp_a, exp_b;
  logic         exp_ci;
  int           lo, m, j;

  always @(posedge clk) begin
    if (!rst_n) begin
      p = 0; ea = '0; eb = '0; ec = 1'b0; eres = '0; ecout = 1'b0;
    end else if (p == 0) begin
      if (start) begin
        ea   = op_a;
        eb   = op_b;
        ec   = cin;
        esum = {1'b0, op_a} + {1'b0, op_b} + (W+1)'(cin);
        eres = '0;
        p    = 1;
      end
    end else if (p <= int'(N)) begin
      eres[2*(p-1) +: 2] = esum[2*(p-1) +: 2];
      if (p == int'(N)) ecout = esum[W];
      p++;
    end else begin
      p = 0;
    end

    #1;
    exp_a  = 2'b00;
    exp_b  = 2'b00;
    exp_ci = 1'b0;
    if (p >= 1 && p <= int'(N)) begin
      j      = p - 1;
      exp_a  = ea[2*j +: 2];
      exp_b  = eb[2*j +: 2];
      m      = (1 << (2*j)) - 1;
      lo     = (int'(ea) & m) + (int'(eb) & m) + int'(ec);
      exp_ci = 1'((lo >> (2*j)) & 1);
    end
    if (done === 1'b1) done_seen++;
    chk("busy",    32'(busy),    32'(p != 0));
    chk("done",    32'(done),    32'(p == int'(N) + 1));
    chk("result",  32'(result),  32'(eres));
    chk("cout",    32'(cout),    32'(ecout));
    chk("add_a",   32'(add_a),   32'(exp_a));
    chk("add_b",   32'(add_b),   32'(exp_b));
    chk("add_cin", 32'(add_cin), 32'(exp_ci));
  end

  logic [1:0] aseq[$];

  // One operation: accept, optionally disturb operands, wait for done, pin result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic chg, input logic [W-1:0] mid_a,
                        input logic [W-1:0] xr, input logic xc, input string tag);
    logic got;
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    aseq.delete();
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      aseq.push_back(add_a);
      if (chg) begin
        op_a = mid_a; op_b = ~b; cin = ~c;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_result"}, 32'(result), 32'(xr));
    chk({tag, "_cout"}, 32'(cout), 32'(xc));
    chk({tag, "_latency"}, 32'(aseq.size()), 32'(N));
    @(negedge clk);
  endtask

  int d0;

  initial begin
    // 1: reset with start held high
    #1;
    rst_n = 1'b0; start = 1'b1; op_a = 8'h11; op_b = 8'h22;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", 32'(result), 32'h00);
    chk("rst_cout",   32'(cout),   32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // 2: 0xA5 + 0x5A + 1
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "t2");
    if (aseq.size() == 4) begin
      chk("t2_add_a0", 32'(aseq[0]), 32'd1);
      chk("t2_add_a1", 32'(aseq[1]), 32'd1);
      chk("t2_add_a2", 32'(aseq[2]), 32'd2);
      chk("t2_add_a3", 32'(aseq[3]), 32'd2);
    end

    // 3: full ripple
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "t3");

    // 4: operands disturbed after accept
    run_op(8'h12, 8'h34, 1'b0, 1'b1, 8'hFF, 8'h46, 1'b0, "t4");

    // 5: start held high for 20 cycles
    @(negedge clk);
    op_a = 8'h0F; op_b = 8'h01; cin = 1'b0; start = 1'b1;
    d0 = done_seen;
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_done_count", 32'(done_seen - d0), 32'd4);
    chk("t5_result", 32'(result), 32'h10);

    // 6: reset during slice 2, then a clean operation
    @(negedge clk);
    op_a = 8'h33; op_b = 8'h44; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    d0 = done_seen;
    repeat (2) @(negedge clk);
    chk("t6_abort_result", 32'(result), 32'h00);
    chk("t6_abort_busy",   32'(busy),   32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_no_done", 32'(done_seen - d0), 32'd0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, "t6");

    // Random traffic with occasional resets; checked by the model each cycle.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op_a  = 8'($urandom);
      op_b  = 8'($urandom);
      cin   = 1'($urandom);
      rst_n = ($urandom_range(0, 80) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $fatal(1, "timeout");
  end

endmodule
